// File: rtl/uart_block_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_block_serializer: slices one wide block into UART bytes over tx_start/tx_done.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_block_serializer #(
  parameter int DBITS     = 8,
  parameter int NBYTES    = 8,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 2000000,
  parameter int TO_BITS   = 21
) (
  input  logic                           clk_100MHz,
  input  logic                           reset,
  input  logic                           blk_valid,
  output logic                           blk_ready,
  input  logic [DBITS*NBYTES-1:0]        blk_data,
  input  logic                           abort,
  output logic                           tx_start,
  output logic [DBITS-1:0]               tx_data,
  input  logic                           tx_done,
  output logic                           busy,
  output logic [$clog2(NBYTES+1)-1:0]    byte_idx,
  output logic                           blk_done,
  output logic                           err_timeout
);

  localparam int c_bw = DBITS * NBYTES;
  localparam int c_iw = $clog2(NBYTES + 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;

  localparam logic [c_iw-1:0]    c_last_idx = c_iw'(NBYTES - 1);
  localparam logic [TO_BITS-1:0] c_wd_last  = TO_BITS'(TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [c_bw-1:0]    r_shift;
  logic [c_bw-1:0]    w_shifted;
  logic [c_iw-1:0]    r_byte_idx;
  logic [TO_BITS-1:0] r_wd;
  logic               r_blk_done;
  logic               w_accept;
  logic               w_last;
  logic               w_expire;

  // abort outranks accept even while idle
  assign w_accept  = (r_state == c_idle) && blk_valid && !abort;
  assign w_last    = (r_byte_idx == c_last_idx);
  assign w_expire  = (TIMEOUT != 0) && (r_wd == c_wd_last) && !tx_done && !abort;
  assign w_shifted = (MSB_FIRST != 0) ? (r_shift << DBITS) : (r_shift >> DBITS);

  assign tx_data  = (MSB_FIRST != 0) ? r_shift[c_bw-1 -: DBITS] : r_shift[DBITS-1:0];
  assign byte_idx = r_byte_idx;
  assign blk_done = r_blk_done;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) r_state <= c_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_next = c_issue;
      c_issue: w_next = abort ? c_idle : c_wait;
      c_wait: begin
        if (abort)         w_next = c_idle;
        else if (tx_done)  w_next = w_last ? c_idle : c_issue;
        else if (w_expire) w_next = c_idle;
      end
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    tx_start    = 1'b0;
    busy        = 1'b0;
    blk_ready   = 1'b0;
    err_timeout = 1'b0;
    case (r_state)
      c_idle:  blk_ready = 1'b1;
      c_issue: begin
        tx_start = 1'b1;
        busy     = 1'b1;
      end
      c_wait: begin
        busy        = 1'b1;
        err_timeout = w_expire;
      end
      default: ;
    endcase
  end

  // byte_idx stays at NBYTES for the blk_done cycle, then clears in IDLE
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_wd       <= '0;
      r_blk_done <= 1'b0;
    end else begin
      r_blk_done <= 1'b0;
      case (r_state)
        c_idle: begin
          r_byte_idx <= '0;
          if (w_accept) r_shift <= blk_data;
        end
        c_issue: begin
          r_wd <= '0;
          if (abort) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
          end
        end
        c_wait: begin
          r_wd <= r_wd + 1'b1;
          if (abort || w_expire) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
          end else if (tx_done) begin
            r_byte_idx <= r_byte_idx + 1'b1;
            if (w_last) begin
              r_blk_done <= 1'b1;
              r_shift    <= '0;
            end else begin
              r_shift <= w_shifted;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
